switch_core_n: RTL and testbench

SWITCH_CORE_N -- requirements
Module: switch_core_n

---
 rtl/switch_core_n.sv | 230 +++++++++++++++++++++++
 tb/tb_switch_core_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_core_n.sv
// Three-stage switch core: main FIFO -> per-VC FIFOs -> per-destination FIFOs, with a control FSM.
// Define SWITCH_CORE_RR_ARB_EN for a round-robin VC arbiter; the default build uses fixed priority.
module switch_core_n #(
   parameter int DATA_SIZE  = 6,
   parameter int NUM_VC     = 2,
   parameter int NUM_DEST   = 2,
   parameter int MAIN_DEPTH = 8,
   parameter int VC_DEPTH   = 16,
   parameter int D_DEPTH    = 4,
   localparam int MAW = $clog2(MAIN_DEPTH) + 1,
   localparam int VAW = $clog2(VC_DEPTH) + 1,
   localparam int DAW = $clog2(D_DEPTH) + 1,
   localparam int NF  = 1 + NUM_VC + NUM_DEST
) (
   input  logic                          clk,
   input  logic                          reset_L,
   input  logic                          init,
   input  logic [DATA_SIZE-1:0]          data_in,
   input  logic                          push_main,
   input  logic [NUM_DEST-1:0]           pop_d,
   input  logic [MAW-1:0]                af_mf_i,
   input  logic [MAW-1:0]                ae_mf_i,
   input  logic [VAW-1:0]                af_vc_i,
   input  logic [VAW-1:0]                ae_vc_i,
   input  logic [DAW-1:0]                af_d_i,
   input  logic [DAW-1:0]                ae_d_i,
   output logic                          pause_main,
   output logic [NUM_DEST-1:0]           empty_d,
   output logic [NUM_DEST*DATA_SIZE-1:0] data_out,
   output logic [NUM_DEST-1:0]           valid_out,
   output logic [NF-1:0]                 error_out,
   output logic                          active_out,
   output logic                          idle_out
);
   localparam int VB  = $clog2(NUM_VC);
   localparam int DB  = $clog2(NUM_DEST);
   localparam int MPW = $clog2(MAIN_DEPTH);
   localparam int VPW = $clog2(VC_DEPTH);
   localparam int DPW = $clog2(D_DEPTH);

   typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
   state_t state, state_nx;

   logic [MAW-1:0] af_mf, ae_mf;
   logic [VAW-1:0] af_vc, ae_vc;
   logic [DAW-1:0] af_d, ae_d;

   logic [DATA_SIZE-1:0] main_mem [MAIN_DEPTH];
   logic [MPW-1:0]       main_wr, main_rd;
   logic [MAW-1:0]       main_cnt;
   logic [DATA_SIZE-1:0] vc_mem [NUM_VC][VC_DEPTH];
   logic [VPW-1:0]       vc_wr [NUM_VC];
   logic [VPW-1:0]       vc_rd [NUM_VC];
   logic [VAW-1:0]       vc_cnt [NUM_VC];
   logic [DATA_SIZE-1:0] d_mem [NUM_DEST][D_DEPTH];
   logic [DPW-1:0]       d_wr [NUM_DEST];
   logic [DPW-1:0]       d_rd [NUM_DEST];
   logic [DAW-1:0]       d_cnt [NUM_DEST];

   logic                 op_en, any_data, main_push, main_pop, main_oflow, grant_any;
   logic [DATA_SIZE-1:0] main_head;
   logic [VB-1:0]        main_head_vc, grant, idx;
   logic [DATA_SIZE-1:0] vc_head [NUM_VC];
   logic [DB-1:0]        vc_head_dest [NUM_VC];
   logic [NUM_VC-1:0]    vc_elig, vc_accept, vc_push, vc_pop;
   logic [NUM_DEST-1:0]  d_accept, d_push, d_pop, d_uflow;
   logic [NF-1:0]        err_nx;
`ifdef SWITCH_CORE_RR_ARB_EN
   logic [VB-1:0]        rr_ptr;
`endif

   // Nothing moves while thresholds are being (re)loaded.
   assign op_en        = (state != S_RESET) && (state != S_INIT);
   assign main_head    = main_mem[main_rd];
   assign main_head_vc = main_head[DATA_SIZE-1 -: VB];

   always_comb begin
      any_data = (main_cnt != '0);
      for (int v = 0; v < NUM_VC; v++) begin
         vc_head[v]      = vc_mem[v][vc_rd[v]];
         vc_head_dest[v] = vc_head[v][DATA_SIZE-1-VB -: DB];
         any_data        = any_data | (vc_cnt[v] != '0);
      end
      for (int k = 0; k < NUM_DEST; k++) any_data = any_data | (d_cnt[k] != '0);
   end

   always_comb begin
      d_pop    = '0;
      d_uflow  = '0;
      d_accept = '0;
      for (int k = 0; k < NUM_DEST; k++) begin
         d_pop[k]    = op_en && pop_d[k] && (d_cnt[k] != '0);
         d_uflow[k]  = op_en && pop_d[k] && (d_cnt[k] == '0);
         d_accept[k] = (d_cnt[k] < af_d) && ((d_cnt[k] < DAW'(D_DEPTH)) || d_pop[k]);
      end
   end

   // Scan from lowest to highest priority so the last hit wins.
   always_comb begin
      vc_elig   = '0;
      grant     = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int v = 0; v < NUM_VC; v++)
         vc_elig[v] = op_en && (vc_cnt[v] != '0) && d_accept[vc_head_dest[v]];
      for (int i = NUM_VC - 1; i >= 0; i--) begin
`ifdef SWITCH_CORE_RR_ARB_EN
         idx = rr_ptr + VB'(i);
`else
         idx = VB'(i);
`endif
         if (vc_elig[idx]) begin
            grant     = idx;
            grant_any = 1'b1;
         end
      end
   end

   always_comb begin
      vc_pop    = '0;
      vc_push   = '0;
      vc_accept = '0;
      d_push    = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         vc_pop[v]    = grant_any && (grant == VB'(v));
         vc_accept[v] = (vc_cnt[v] < af_vc) && ((vc_cnt[v] < VAW'(VC_DEPTH)) || vc_pop[v]);
      end
      for (int k = 0; k < NUM_DEST; k++)
         d_push[k] = grant_any && (vc_head_dest[grant] == DB'(k));
      main_pop   = op_en && (main_cnt != '0) && vc_accept[main_head_vc];
      for (int v = 0; v < NUM_VC; v++)
         vc_push[v] = main_pop && (main_head_vc == VB'(v));
      main_push  = op_en && push_main && ((main_cnt < MAW'(MAIN_DEPTH)) || main_pop);
      main_oflow = op_en && push_main && !main_push;
      err_nx     = error_out | NF'(main_oflow);
      for (int k = 0; k < NUM_DEST; k++)
         err_nx[1+NUM_VC+k] = error_out[1+NUM_VC+k] | d_uflow[k];
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_RESET:  state_nx = S_INIT;
         S_INIT:   if (!init) state_nx = S_IDLE;
         S_IDLE:   if (init) state_nx = S_INIT; else if (any_data) state_nx = S_ACTIVE;
         S_ACTIVE: if (init) state_nx = S_INIT; else if (!any_data) state_nx = S_IDLE;
         default:  state_nx = S_ERROR;
      endcase
      if ((state != S_RESET) && (|error_out)) state_nx = S_ERROR;
   end

   // Storage arrays carry no reset; stale words are unreachable once counts clear.
   always_ff @(posedge clk) begin
      if (main_push) main_mem[main_wr] <= data_in;
      for (int v = 0; v < NUM_VC; v++)
         if (vc_push[v]) vc_mem[v][vc_wr[v]] <= main_head;
      for (int k = 0; k < NUM_DEST; k++)
         if (d_push[k]) d_mem[k][d_wr[k]] <= vc_head[grant];
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state     <= S_RESET;
         af_mf     <= MAW'(MAIN_DEPTH - 1);
         ae_mf     <= MAW'(1);
         af_vc     <= VAW'(VC_DEPTH - 1);
         ae_vc     <= VAW'(1);
         af_d      <= DAW'(D_DEPTH - 1);
         ae_d      <= DAW'(1);
         main_wr   <= '0;
         main_rd   <= '0;
         main_cnt  <= '0;
         for (int v = 0; v < NUM_VC; v++) begin
            vc_wr[v]  <= '0;
            vc_rd[v]  <= '0;
            vc_cnt[v] <= '0;
         end
         for (int k = 0; k < NUM_DEST; k++) begin
            d_wr[k]  <= '0;
            d_rd[k]  <= '0;
            d_cnt[k] <= '0;
         end
         data_out  <= '0;
         valid_out <= '0;
         error_out <= '0;
`ifdef SWITCH_CORE_RR_ARB_EN
         rr_ptr    <= '0;
`endif
      end else begin
         state     <= state_nx;
         error_out <= err_nx;
         if (state == S_INIT) begin
            af_mf <= af_mf_i;
            ae_mf <= ae_mf_i;
            af_vc <= af_vc_i;
            ae_vc <= ae_vc_i;
            af_d  <= af_d_i;
            ae_d  <= ae_d_i;
         end
         if (main_push) main_wr <= main_wr + MPW'(1);
         if (main_pop)  main_rd <= main_rd + MPW'(1);
         main_cnt <= main_cnt + MAW'(main_push) - MAW'(main_pop);
         for (int v = 0; v < NUM_VC; v++) begin
            if (vc_push[v]) vc_wr[v] <= vc_wr[v] + VPW'(1);
            if (vc_pop[v])  vc_rd[v] <= vc_rd[v] + VPW'(1);
            vc_cnt[v] <= vc_cnt[v] + VAW'(vc_push[v]) - VAW'(vc_pop[v]);
         end
         for (int k = 0; k < NUM_DEST; k++) begin
            if (d_push[k]) d_wr[k] <= d_wr[k] + DPW'(1);
            if (d_pop[k]) begin
               d_rd[k] <= d_rd[k] + DPW'(1);
               data_out[k*DATA_SIZE +: DATA_SIZE] <= d_mem[k][d_rd[k]];
            end
            d_cnt[k] <= d_cnt[k] + DAW'(d_push[k]) - DAW'(d_pop[k]);
         end
         valid_out <= d_pop;
`ifdef SWITCH_CORE_RR_ARB_EN
         if (grant_any) rr_ptr <= grant + VB'(1);
`endif
      end
   end

   always_comb begin
      pause_main = op_en ? (main_cnt >= af_mf) : 1'b1;
      for (int k = 0; k < NUM_DEST; k++) empty_d[k] = (d_cnt[k] == '0);
   end

   assign active_out = (state == S_ACTIVE);
   assign idle_out   = (state == S_IDLE);
endmodule

// File: tb/tb_switch_core_n.sv
// Directed bench for switch_core_n: reset/init, single word path, arbitration order,
// destination underflow and main-FIFO overflow.
module tb_switch_core_n;
   logic        clk = 1'b0;
   logic        reset_L, init, push_main;
   logic [5:0]  data_in;
   logic [1:0]  pop_d;
   logic [3:0]  af_mf_i, ae_mf_i;
   logic [4:0]  af_vc_i, ae_vc_i;
   logic [2:0]  af_d_i, ae_d_i;
   logic        pause_main, active_out, idle_out;
   logic [1:0]  empty_d, valid_out;
   logic [11:0] data_out;
   logic [4:0]  error_out;

   int n_vec = 0;
   int n_err = 0;

   switch_core_n dut (
      .clk(clk), .reset_L(reset_L), .init(init), .data_in(data_in),
      .push_main(push_main), .pop_d(pop_d),
      .af_mf_i(af_mf_i), .ae_mf_i(ae_mf_i), .af_vc_i(af_vc_i), .ae_vc_i(ae_vc_i),
      .af_d_i(af_d_i), .ae_d_i(ae_d_i),
      .pause_main(pause_main), .empty_d(empty_d), .data_out(data_out),
      .valid_out(valid_out), .error_out(error_out),
      .active_out(active_out), .idle_out(idle_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reset, then hold init for two cycles with the given af thresholds; ends in IDLE.
   task automatic do_init(input logic [3:0] mf, input logic [4:0] vc, input logic [2:0] d);
      reset_L = 1'b0; init = 1'b0; push_main = 1'b0; pop_d = 2'b00; data_in = '0;
      repeat (2) @(negedge clk);
      reset_L = 1'b1; init = 1'b1;
      af_mf_i = mf; af_vc_i = vc; af_d_i = d;
      ae_mf_i = 4'd1; ae_vc_i = 5'd1; ae_d_i = 3'd1;
      repeat (2) @(negedge clk);
      init = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset_L = 1'b0; init = 1'b0; push_main = 1'b0; pop_d = 2'b00; data_in = '0;
      af_mf_i = 4'd6; af_vc_i = 5'd15; af_d_i = 3'd3;
      ae_mf_i = 4'd1; ae_vc_i = 5'd1; ae_d_i = 3'd1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({pause_main, empty_d, valid_out, data_out, error_out, active_out, idle_out} !==
          {1'b1, 2'b11, 2'b00, 12'h000, 5'b00000, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got pause=%b empty=%b valid=%b data=%h err=%b act=%b idle=%b",
                  pause_main, empty_d, valid_out, data_out, error_out, active_out, idle_out);
      end
      reset_L = 1'b1; init = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({idle_out, active_out, pause_main} !== 3'b001) begin
         n_err++;
         $display("FAIL init_hold: got idle=%b act=%b pause=%b, want 0 0 1", idle_out, active_out, pause_main);
      end
      init = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({idle_out, active_out, pause_main} !== 3'b100) begin
         n_err++;
         $display("FAIL init_to_idle: got idle=%b act=%b pause=%b, want 1 0 0", idle_out, active_out, pause_main);
      end
   endtask

   task automatic test_single;
      do_init(4'd7, 5'd15, 3'd3);
      data_in = 6'h2A; push_main = 1'b1;
      @(negedge clk);
      push_main = 1'b0;
      n_vec++;
      if (empty_d[0] !== 1'b1) begin
         n_err++; $display("FAIL single_e1: empty_d[0]=%b want 1", empty_d[0]);
      end
      @(negedge clk);
      n_vec++;
      if ({empty_d[0], active_out} !== 2'b11) begin
         n_err++; $display("FAIL single_e2: empty_d[0]=%b act=%b want 1 1", empty_d[0], active_out);
      end
      @(negedge clk);
      n_vec++;
      if (empty_d !== 2'b10) begin
         n_err++; $display("FAIL single_e3: empty_d=%b want 10", empty_d);
      end
      pop_d = 2'b01;
      @(negedge clk);
      pop_d = 2'b00;
      n_vec++;
      if ({valid_out, data_out[5:0], empty_d} !== {2'b01, 6'h2A, 2'b11}) begin
         n_err++;
         $display("FAIL single_pop: valid=%b data=%h empty=%b want 01 2a 11", valid_out, data_out[5:0], empty_d);
      end
      @(negedge clk);
      n_vec++;
      if ({valid_out, data_out[5:0], idle_out, error_out} !== {2'b00, 6'h2A, 1'b1, 5'b00000}) begin
         n_err++;
         $display("FAIL single_after: valid=%b data=%h idle=%b err=%b want 00 2a 1 00000",
                  valid_out, data_out[5:0], idle_out, error_out);
      end
   endtask

   task automatic test_arbitration;
      logic [5:0] words [6];
      logic [5:0] exp_q [$];
      logic [5:0] exp;
      words = '{6'h01, 6'h02, 6'h03, 6'h21, 6'h22, 6'h23};
`ifdef SWITCH_CORE_RR_ARB_EN
      exp_q = '{6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};
`else
      exp_q = '{6'h01, 6'h02, 6'h03, 6'h21, 6'h22, 6'h23};
`endif
      do_init(4'd7, 5'd15, 3'd0);
      for (int i = 0; i < 6; i++) begin
         data_in = words[i]; push_main = 1'b1;
         @(negedge clk);
      end
      push_main = 1'b0;
      repeat (6) @(negedge clk);
      n_vec++;
      if ({empty_d, error_out} !== {2'b11, 5'b00000}) begin
         n_err++; $display("FAIL arb_load: empty=%b err=%b want 11 00000", empty_d, error_out);
      end
      init = 1'b1; af_d_i = 3'd3;
      @(negedge clk);
      init = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         pop_d = {1'b0, ~empty_d[0]};
         @(negedge clk);
         if (valid_out[0]) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (data_out[5:0] !== exp) begin
               n_err++; $display("FAIL arb_order: got %h want %h", data_out[5:0], exp);
            end
         end
      end
      pop_d = 2'b00;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL arb_timeout: %0d words never arrived, want 0", exp_q.size());
      end
      n_vec++;
      if (error_out !== 5'b00000) begin
         n_err++; $display("FAIL arb_err: err=%b want 00000", error_out);
      end
   endtask

   task automatic test_underflow;
      do_init(4'd7, 5'd15, 3'd3);
      pop_d = 2'b10;
      @(negedge clk);
      pop_d = 2'b00;
      n_vec++;
      if ({valid_out, error_out, empty_d} !== {2'b00, 5'b10000, 2'b11}) begin
         n_err++;
         $display("FAIL underflow: valid=%b err=%b empty=%b want 00 10000 11", valid_out, error_out, empty_d);
      end
      @(negedge clk);
      n_vec++;
      if ({active_out, idle_out} !== 2'b00) begin
         n_err++; $display("FAIL underflow_fsm: act=%b idle=%b want 0 0", active_out, idle_out);
      end
   endtask

   task automatic test_overflow;
      logic exp_pause, exp_err;
      do_init(4'd6, 5'd0, 3'd3);
      for (int i = 1; i <= 9; i++) begin
         data_in = 6'(i); push_main = 1'b1;
         @(negedge clk);
         exp_pause = (i >= 6);
         exp_err   = (i == 9);
         n_vec++;
         if ({pause_main, error_out[0]} !== {exp_pause, exp_err}) begin
            n_err++;
            $display("FAIL overflow_push%0d: pause=%b err0=%b want %b %b",
                     i, pause_main, error_out[0], exp_pause, exp_err);
         end
      end
      push_main = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({active_out, idle_out, empty_d} !== {1'b0, 1'b0, 2'b11}) begin
         n_err++;
         $display("FAIL overflow_fsm: act=%b idle=%b empty=%b want 0 0 11", active_out, idle_out, empty_d);
      end
      reset_L = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({error_out, pause_main, empty_d} !== {5'b00000, 1'b1, 2'b11}) begin
         n_err++;
         $display("FAIL reset_clear: err=%b pause=%b empty=%b want 00000 1 11", error_out, pause_main, empty_d);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_arbitration();
      test_underflow();
      test_overflow();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
